// File: rtl/adder_nbit.sv
// Registered N-bit unsigned adder with carry-out flag, one cycle of latency.
// Define ADDER_SATURATE_EN to clamp the result to all ones on carry-out instead of wrapping.
module adder_nbit #(
  parameter int N_BITS = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic [N_BITS-1:0] i_operand1,
  input  logic [N_BITS-1:0] i_operand2,
  output logic              o_valid,
  output logic [N_BITS-1:0] o_result,
  output logic              o_overflow
);

  logic [N_BITS:0]   sum;
  logic [N_BITS-1:0] next_result;

  // The extra top bit of the zero-extended sum is the carry-out.
  assign sum = {1'b0, i_operand1} + {1'b0, i_operand2};

  always_comb begin
`ifdef ADDER_SATURATE_EN
    next_result = sum[N_BITS] ? {N_BITS{1'b1}} : sum[N_BITS-1:0];
`else
    next_result = sum[N_BITS-1:0];
`endif
  end

  // Result and flag only load on valid cycles; otherwise they hold while o_valid drops.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid    <= 1'b0;
      o_result   <= '0;
      o_overflow <= 1'b0;
    end else begin
      o_valid <= i_valid;
      if (i_valid) begin
        o_result   <= next_result;
        o_overflow <= sum[N_BITS];
      end
    end
  end

endmodule

// File: tb/tb_adder_nbit.sv
// Bench for adder_nbit: vector table, reset corner cases and random ops checked through a scoreboard queue.
module tb_adder_nbit;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         valid = 1'b0;
  logic [N-1:0] op1 = '0;
  logic [N-1:0] op2 = '0;
  logic         o_valid;
  logic [N-1:0] o_result;
  logic         o_overflow;

  adder_nbit #(.N_BITS(N)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid),
    .i_operand1(op1), .i_operand2(op2),
    .o_valid(o_valid), .o_result(o_result), .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         v;
    logic [N-1:0] res;
    logic         ovf;
  } exp_t;

  typedef struct {
    logic         v;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] res;
    logic         ovf;
  } vec_t;

  exp_t         sb[$];
  logic [N-1:0] held_res = '0;
  logic         held_ovf = 1'b0;
  int           errors = 0;
  int           checks = 0;

`ifdef ADDER_SATURATE_EN
  localparam logic [N-1:0] SAT_255_1   = 8'd255;
  localparam logic [N-1:0] SAT_200_100 = 8'd255;
  localparam logic [N-1:0] SAT_255_255 = 8'd255;
`else
  localparam logic [N-1:0] SAT_255_1   = 8'd0;
  localparam logic [N-1:0] SAT_200_100 = 8'd44;
  localparam logic [N-1:0] SAT_255_255 = 8'd254;
`endif

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model for one operation, independent of the RTL structure.
  function automatic exp_t model(input logic v, input int a, input int b);
    exp_t e;
    int   s;
    s = a + b;
    e.v = v;
    if (v) begin
      e.ovf = (s >= 256);
`ifdef ADDER_SATURATE_EN
      e.res = (s >= 256) ? 8'd255 : s[N-1:0];
`else
      e.res = s[N-1:0];
`endif
    end else begin
      e.res = held_res;
      e.ovf = held_ovf;
    end
    return e;
  endfunction

  // Drive at the falling edge, push the expectation, compare at the next falling edge.
  task automatic cycle(input string name, input logic v, input logic [N-1:0] a,
                       input logic [N-1:0] b, input exp_t e);
    exp_t got;
    valid = v; op1 = a; op2 = b;
    sb.push_back(e);
    held_res = e.res;
    held_ovf = e.ovf;
    @(posedge clk);
    @(negedge clk);
    got = sb.pop_front();
    check({name, ".valid"},    o_valid,    got.v);
    check({name, ".result"},   o_result,   got.res);
    check({name, ".overflow"}, o_overflow, got.ovf);
  endtask

  initial begin
    vec_t vecs[$];
    exp_t e;
    vecs = '{
      '{1'b1, 8'd255, 8'd1,   SAT_255_1,   1'b1},
      '{1'b1, 8'd100, 8'd27,  8'd127,      1'b0},
      '{1'b1, 8'd200, 8'd100, SAT_200_100, 1'b1},
      '{1'b1, 8'd10,  8'd20,  8'd30,       1'b0},
      '{1'b1, 8'd255, 8'd255, SAT_255_255, 1'b1},
      '{1'b1, 8'd0,   8'd0,   8'd0,        1'b0},
      '{1'b1, 8'd3,   8'd4,   8'd7,        1'b0},
      '{1'b0, 8'd9,   8'd9,   8'd7,        1'b0},
      '{1'b0, 8'd250, 8'd250, 8'd7,        1'b0},
      '{1'b1, 8'd128, 8'd127, 8'd255,      1'b0},
      '{1'b1, 8'd1,   8'd254, 8'd255,      1'b0}
    };

    // Reset held from time zero.
    #2;
    check("rst0.valid",    o_valid,    0);
    check("rst0.result",   o_result,   0);
    check("rst0.overflow", o_overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    // Idle after reset: outputs stay at reset values.
    cycle("idle", 1'b0, 8'd55, 8'd66, model(1'b0, 55, 66));

    foreach (vecs[i])
      cycle($sformatf("vec%0d", i), vecs[i].v, vecs[i].a, vecs[i].b,
            '{vecs[i].v, vecs[i].res, vecs[i].ovf});

    // Load a nonzero result, then reset asynchronously mid-cycle with another op in flight.
    cycle("pre_rst", 1'b1, 8'd200, 8'd60, model(1'b1, 200, 60));
    valid = 1'b1; op1 = 8'd90; op2 = 8'd9;
    #2 rst_n = 1'b0;
    #1;
    check("arst.valid",    o_valid,    0);
    check("arst.result",   o_result,   0);
    check("arst.overflow", o_overflow, 0);
    @(posedge clk);
    @(negedge clk);
    check("arst_hold.result", o_result, 0);
    rst_n = 1'b1;
    held_res = '0;
    held_ovf = 1'b0;
    cycle("post_rst_idle", 1'b0, 8'd90, 8'd9, model(1'b0, 90, 9));
    cycle("post_rst_op",   1'b1, 8'd90, 8'd9, model(1'b1, 90, 9));

    // Random operands with occasional idle cycles.
    for (int i = 0; i < 500; i++) begin
      logic         v;
      logic [N-1:0] a, b;
      v = ($urandom_range(0, 7) != 0);
      a = N'($urandom_range(0, 255));
      b = N'($urandom_range(0, 255));
      e = model(v, int'(a), int'(b));
      cycle("rand", v, a, b, e);
    end

    valid = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
